// File: rtl/soc_int_cond_pkg.sv
// +----------------------------------------------------------------------------+
// | soc_int_cond_pkg                                                           |
// | Shared types and limits for the external interrupt conditioner.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package soc_int_cond_pkg;

  localparam int INT_COND_MAX_LINES = 32;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMING    = 2'd1,
    ACTIVE    = 2'd2,
    RELEASING = 2'd3
  } int_line_state_t;

endpackage

`default_nettype wire

// File: rtl/soc_int_line.sv
// +----------------------------------------------------------------------------+
// | soc_int_line                                                               |
// | One interrupt line: polarity, synchroniser, debounce FSM, trigger output.  |
// | Debounce (ARMING/RELEASING + counter) exists only with SOC_INT_DEBOUNCE_EN.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module soc_int_line
  import soc_int_cond_pkg::*;
#(
  parameter bit EDGE_MODE       = 1'b1,
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic res_n,
  input  logic i_pin,
  input  logic i_en,
  output logic o_trig,
  output logic o_active
);

  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1) begin : g_bad_params
    $error("soc_int_line: SYNC_STAGES must be >= 2 and DEBOUNCE_CYCLES >= 1");
  end

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   w_s;
  int_line_state_t        r_state;
  int_line_state_t        w_state_nxt;
  logic                   r_trig;
  logic                   w_trig_nxt;
  logic                   w_active;
  logic                   w_active_nxt;
  logic                   w_rise;

  // Polarity is folded in before the first flop so reset means "deasserted".
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin ^ ACTIVE_LOW};
    end
  end

  assign w_s = r_sync[SYNC_STAGES-1];

`ifdef SOC_INT_DEBOUNCE_EN
  localparam int               CNT_W     = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
`endif

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      r_state <= IDLE;
      r_trig  <= 1'b0;
`ifdef SOC_INT_DEBOUNCE_EN
      r_cnt   <= '0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_trig  <= w_trig_nxt;
`ifdef SOC_INT_DEBOUNCE_EN
      r_cnt   <= w_cnt_nxt;
`endif
    end
  end

`ifdef SOC_INT_DEBOUNCE_EN
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (!i_en) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_s) begin
            w_state_nxt = ARMING;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end
        ARMING: begin
          if (!w_s) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_MAX) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
          end
        end
        ACTIVE: begin
          if (!w_s) begin
            w_state_nxt = RELEASING;
            w_cnt_nxt   = c_CNT_ONE;
          end
        end
        RELEASING: begin
          if (w_s) begin
            w_state_nxt = ACTIVE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_MAX) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + c_CNT_ONE;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    w_state_nxt = r_state;
    if (!i_en) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE:    if (w_s)  w_state_nxt = ACTIVE;
        ACTIVE:  if (!w_s) w_state_nxt = IDLE;
        default: w_state_nxt = IDLE;
      endcase
    end
  end
`endif

  // Outputs are registered from the next state so the pulse lands on the same
  // edge that enters ACTIVE; RELEASING->ACTIVE is deliberately not a rise.
  always_comb begin
    w_active     = (r_state == ACTIVE) || (r_state == RELEASING);
    w_active_nxt = (w_state_nxt == ACTIVE) || (w_state_nxt == RELEASING);
    w_rise       = (w_state_nxt == ACTIVE) && ((r_state == IDLE) || (r_state == ARMING));
    w_trig_nxt   = EDGE_MODE ? w_rise : w_active_nxt;
  end

  assign o_trig   = r_trig;
  assign o_active = w_active;

endmodule

`default_nettype wire

// File: rtl/soc_int_conditioner.sv
// +----------------------------------------------------------------------------+
// | soc_int_conditioner                                                        |
// | Per-line interrupt conditioner feeding the SoC controller int_triggers.    |
// | Optional debounce enabled by macro SOC_INT_DEBOUNCE_EN.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module soc_int_conditioner
  import soc_int_cond_pkg::*;
#(
  parameter int          NUM_LINES       = 8,
  parameter int          SYNC_STAGES     = 2,
  parameter int          DEBOUNCE_CYCLES = 16,
  parameter logic [31:0] EDGE_MASK       = 32'hFFFF_FFFF,
  parameter logic [31:0] ACTIVE_LOW_MASK = 32'h0000_0000
) (
  input  logic                 clk,
  input  logic                 res_n,
  input  logic [NUM_LINES-1:0] ext_int,
  input  logic [NUM_LINES-1:0] line_en,
  output logic [31:0]          int_triggers,
  output logic [NUM_LINES-1:0] line_active
);

  if (NUM_LINES < 1 || NUM_LINES > INT_COND_MAX_LINES) begin : g_bad_lines
    $error("soc_int_conditioner: NUM_LINES must be 1..32");
  end

  logic [NUM_LINES-1:0] w_trig;

  for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
    soc_int_line #(
      .EDGE_MODE       (EDGE_MASK[gi]),
      .ACTIVE_LOW      (ACTIVE_LOW_MASK[gi]),
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_line (
      .clk      (clk),
      .res_n    (res_n),
      .i_pin    (ext_int[gi]),
      .i_en     (line_en[gi]),
      .o_trig   (w_trig[gi]),
      .o_active (line_active[gi])
    );
  end

  if (NUM_LINES < INT_COND_MAX_LINES) begin : g_pad
    assign int_triggers = {{(INT_COND_MAX_LINES - NUM_LINES){1'b0}}, w_trig};
  end else begin : g_full
    assign int_triggers = w_trig;
  end

endmodule

`default_nettype wire
